// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, ID redirects,
// data-memory freezes with a watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             stall_all_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DEAD     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use_c;
    logic redirect_c;
    logic dec_pc_write;
    logic dec_ifid_write;
    logic dec_ifid_flush;
    logic dec_idex_bubble;

    // Unfrozen decode: load-use wins over redirect, which wins over normal flow.
    always_comb begin
        load_use_c = ex_memread_i && (ex_rt_i != 5'd0) &&
                     ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        redirect_c = branch_taken_i || jump_i;
        dec_pc_write    = 1'b1;
        dec_ifid_write  = 1'b1;
        dec_ifid_flush  = 1'b0;
        dec_idex_bubble = 1'b0;
        if (load_use_c) begin
            dec_pc_write    = 1'b0;
            dec_ifid_write  = 1'b0;
            dec_idex_bubble = 1'b1;
        end else if (redirect_c) begin
            dec_ifid_flush  = 1'b1;
        end
    end

    // Next-state, watchdog, control outputs and counter updates.
    always_comb begin
        state_d        = state_q;
        wdog_d         = wdog_q;
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        stall_all_o    = 1'b0;
        timeout_o      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall_i) begin
                    stall_all_o = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wdog_d      = WD_W'(1);
                end else begin
                    pc_write_o    = dec_pc_write;
                    ifid_write_o  = dec_ifid_write;
                    ifid_flush_o  = dec_ifid_flush;
                    idex_bubble_o = dec_idex_bubble;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall_i) begin
                    stall_all_o = 1'b1;
                    if (wdog_q == WD_W'(TIMEOUT)) begin
                        state_d = ST_DEAD;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end else begin
                    pc_write_o    = dec_pc_write;
                    ifid_write_o  = dec_ifid_write;
                    ifid_flush_o  = dec_ifid_flush;
                    idex_bubble_o = dec_idex_bubble;
                    state_d       = ST_RUN;
                    wdog_d        = '0;
                end
            end
            ST_DEAD: begin
                stall_all_o = 1'b1;
                timeout_o   = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wdog_d  = '0;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if (!pc_write_o && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (ifid_flush_o && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_RUN;
            wdog_q         <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wdog_q         <= wdog_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default, and CNT_W=3/TIMEOUT=4) on shared
// inputs, checked every cycle against a rule-level model plus literal spot checks.
module tb_pipeline_hazard_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
    logic       id_uses_rt_i, ex_memread_i, branch_taken_i, jump_i, mem_stall_i;

    logic        a_pw, a_iw, a_fl, a_bb, a_sa, a_to;
    logic [15:0] a_sc, a_fc;
    logic        b_pw, b_iw, b_fl, b_bb, b_sa, b_to;
    logic [2:0]  b_sc, b_fc;

    pipeline_hazard_ctrl dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .mem_stall_i(mem_stall_i),
        .pc_write_o(a_pw), .ifid_write_o(a_iw), .ifid_flush_o(a_fl), .idex_bubble_o(a_bb),
        .stall_all_o(a_sa), .timeout_o(a_to), .stall_cycles_o(a_sc), .flush_count_o(a_fc)
    );

    pipeline_hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .mem_stall_i(mem_stall_i),
        .pc_write_o(b_pw), .ifid_write_o(b_iw), .ifid_flush_o(b_fl), .idex_bubble_o(b_bb),
        .stall_all_o(b_sa), .timeout_o(b_to), .stall_cycles_o(b_sc), .flush_count_o(b_fc)
    );

    int total = 0;
    int bad   = 0;

    // Model: per instance, consecutive mem-stall count, dead flag and the two counters.
    int unsigned m_run[2];
    int unsigned m_sc[2];
    int unsigned m_fc[2];
    bit          m_dead[2];

    function automatic int unsigned to_of(input int k);
        return (k == 0) ? 255 : 4;
    endfunction

    function automatic int unsigned max_of(input int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, stall_all, timeout}.
    function automatic logic [5:0] model_out(input int k);
        bit lu;
        if (m_dead[k]) return 6'b000011;
        if (mem_stall_i) return 6'b000010;
        lu = ex_memread_i && (ex_rt_i != 0) &&
             ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        if (lu) return 6'b000100;
        if (branch_taken_i || jump_i) return 6'b111000;
        return 6'b110000;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_dead[k] = 1'b0;
        end
    endfunction

    function automatic void model_tick();
        logic [5:0] e;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            if (!e[5] && m_sc[k] < max_of(k)) m_sc[k]++;
            if (e[3] && m_fc[k] < max_of(k)) m_fc[k]++;
            if (!m_dead[k]) begin
                if (mem_stall_i) begin
                    if (m_run[k] == to_of(k)) m_dead[k] = 1'b1;
                    else m_run[k]++;
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        chk("ctl_a", {26'd0, a_pw, a_iw, a_fl, a_bb, a_sa, a_to}, {26'd0, model_out(0)});
        chk("ctl_b", {26'd0, b_pw, b_iw, b_fl, b_bb, b_sa, b_to}, {26'd0, model_out(1)});
        chk("stall_cnt_a", {16'd0, a_sc}, m_sc[0]);
        chk("flush_cnt_a", {16'd0, a_fc}, m_fc[0]);
        chk("stall_cnt_b", {29'd0, b_sc}, m_sc[1]);
        chk("flush_cnt_b", {29'd0, b_fc}, m_fc[1]);
    endtask

    // One clock: check mid-cycle, advance model at the edge, return at posedge+1.
    task automatic step();
        @(negedge clk_i);
        compare();
        @(posedge clk_i);
        model_tick();
        #1;
    endtask

    task automatic clear_in();
        id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0; id_uses_rt_i = 1'b0;
        ex_memread_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        model_reset();
        compare();
        #1;
        rst_i = 1'b1;
    endtask

    int burst;

    initial begin
        rst_i = 1'b0;
        clear_in();
        @(posedge clk_i);
        #1;
        do_reset();

        // Reset state with idle inputs.
        chk("t1_pc_write", {31'd0, a_pw}, 1);
        chk("t1_ifid_write", {31'd0, a_iw}, 1);
        chk("t1_counters", {a_sc, a_fc}, 0);
        step();

        // Load-use stall, then ex_rt=0 does not stall.
        ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
        step();
        chk("t2_stall_one", {16'd0, a_sc}, 1);
        ex_rt_i = 5'd0; id_rs_i = 5'd0;
        step();
        chk("t2_rt0_no_stall", {16'd0, a_sc}, 1);

        // Taken branch flushes; branch with load-use only bubbles.
        clear_in();
        branch_taken_i = 1'b1;
        step();
        chk("t3_flush_one", {16'd0, a_fc}, 1);
        ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
        step();
        chk("t3_no_flush_on_lu", {16'd0, a_fc}, 1);
        chk("t3_stall_two", {16'd0, a_sc}, 2);

        // Ten-cycle mem stall with jump pending; small instance trips its watchdog.
        clear_in();
        mem_stall_i = 1'b1; jump_i = 1'b1;
        repeat (10) step();
        chk("t4_stall_twelve", {16'd0, a_sc}, 12);
        chk("t4_no_flush", {16'd0, a_fc}, 1);
        chk("t5_timeout_b", {31'd0, b_to}, 1);
        chk("t5_no_timeout_a", {31'd0, a_to}, 0);
        mem_stall_i = 1'b0;
        step();
        chk("t4_flush_on_exit", {16'd0, a_fc}, 2);
        chk("t5_timeout_sticky", {31'd0, b_to}, 1);

        // Asynchronous reset pulse in the middle of a cycle.
        clear_in();
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t5_async_clear_to", {31'd0, b_to}, 0);
        chk("t5_async_clear_cnt", {a_sc, 13'd0, b_sc}, 0);
        rst_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        model_tick();
        #1;

        // Nine load-use stalls via rt: small counter saturates at 7.
        ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rt_i = 5'd5; id_uses_rt_i = 1'b1;
        repeat (9) step();
        chk("t6_sat_b", {29'd0, b_sc}, 7);
        chk("t6_nosat_a", {16'd0, a_sc}, 9);

        // Long freeze trips the default watchdog.
        clear_in();
        mem_stall_i = 1'b1;
        repeat (258) step();
        chk("wd_timeout_a", {31'd0, a_to}, 1);
        mem_stall_i = 1'b0;
        step();
        chk("wd_sticky_a", {31'd0, a_to}, 1);
        do_reset();

        // Randomized traffic with bursty mem stalls and occasional resets.
        burst = 0;
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            id_rs_i        = 5'($urandom_range(0, 3));
            id_rt_i        = 5'($urandom_range(0, 3));
            ex_rt_i        = 5'($urandom_range(0, 3));
            id_uses_rt_i   = 1'($urandom_range(0, 1));
            ex_memread_i   = 1'($urandom_range(0, 1));
            branch_taken_i = ($urandom_range(0, 3) == 0);
            jump_i         = ($urandom_range(0, 5) == 0);
            if (burst > 0) begin
                mem_stall_i = 1'b1;
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_stall_i = 1'b1;
                burst = int'($urandom_range(0, 6));
            end else begin
                mem_stall_i = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
